// File: rtl/fetch_pkg.sv
// Types shared by the fetch stage: the 32-bit word and the {pc, ir} record handed to decode.
package fetch_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t ir;
  } id_t;

  localparam word_t RESET_PC_DFLT = 32'h0000_0000;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response channel plus the decode-side stream, as seen by fetch.
interface fetch_if;
  import fetch_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  word_t imem_req_addr;
  logic  imem_rsp_valid;
  word_t imem_rsp_data;
  logic  sink_tvalid;
  logic  sink_tready;
  id_t   sink_tdata;

  modport master (
    output imem_req_valid, imem_req_addr, sink_tvalid, sink_tdata,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, sink_tready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, sink_tvalid, sink_tdata,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, sink_tready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small circular FIFO with synchronous flush (flush beats push/pop) and an occupancy count.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/fetch.sv
// Instruction fetch: issues sequential PC reads, tags returned words with their PC and buffers
// them for decode; a branch redirects the PC and discards everything older still in flight.
module fetch
  import fetch_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DFLT,
  parameter int    DEPTH    = 2
) (
  input  logic    aclk,
  input  logic    areset,
  input  logic    branch,
  input  word_t   target,
  fetch_if.master bus
);
  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [CW+1:0]   DEPTH_W = (CW + 2)'(DEPTH);

  word_t         pc_q, pc_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] pend_cnt, q_cnt;
  word_t         pend_pc;
  id_t           q_head, q_wdata;
  logic          pend_empty, q_empty;
  logic          req_fire, rsp_keep, rsp_drop, sink_pop;
  logic [CW+1:0] inflight;

  assign sink_pop = ~q_empty & bus.sink_tready;

  // Credit counts every request still owed a response (kept or to be discarded) plus queued
  // entries; an entry leaving through the sink this cycle frees its slot now, which is what
  // lets a 1-cycle memory sustain one instruction per cycle.
  assign inflight = {2'b00, pend_cnt} + {2'b00, disc_q} + {2'b00, q_cnt}
                  - {{(CW + 1){1'b0}}, sink_pop};

  assign bus.imem_req_valid = ~areset & ~branch & (inflight < DEPTH_W);
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;

  assign rsp_drop = bus.imem_rsp_valid & (disc_q != '0);
  assign rsp_keep = bus.imem_rsp_valid & (disc_q == '0) & ~pend_empty;
  assign q_wdata  = '{pc: pend_pc, ir: bus.imem_rsp_data};

  assign bus.sink_tvalid = ~q_empty;
  assign bus.sink_tdata  = q_head;

  always_comb begin
    pc_d   = pc_q;
    disc_d = disc_q;
    if (branch) begin
      pc_d   = target & ~32'h3;
      disc_d = pend_cnt + disc_q - CW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) pc_d   = pc_q + 32'd4;
      if (rsp_drop) disc_d = disc_q - CW'(1);
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pc_q   <= RESET_PC;
      disc_q <= '0;
    end else begin
      pc_q   <= pc_d;
      disc_q <= disc_d;
    end
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend (
    .clk_i   (aclk),
    .rst_i   (areset),
    .flush_i (branch),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (rsp_keep),
    .rdata_o (pend_pc),
    .empty_o (pend_empty),
    .count_o (pend_cnt)
  );

  fetch_fifo #(.WIDTH($bits(id_t)), .DEPTH(DEPTH)) u_outq (
    .clk_i   (aclk),
    .rst_i   (areset),
    .flush_i (branch),
    .push_i  (rsp_keep),
    .wdata_i (q_wdata),
    .pop_i   (sink_pop),
    .rdata_o (q_head),
    .empty_o (q_empty),
    .count_o (q_cnt)
  );

endmodule

// File: tb/tb_fetch.sv
// Directed plus short random bench for fetch, with an in-order memory model and a sink scoreboard.
module tb_fetch;
  import fetch_pkg::*;

  localparam word_t RST_PC = 32'h0000_0000;
  localparam int    DEPTH  = 2;

  logic  aclk = 1'b0;
  logic  areset;
  logic  branch;
  word_t target;

  fetch_if bus();

  fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .aclk   (aclk),
    .areset (areset),
    .branch (branch),
    .target (target),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int    due;
    word_t addr;
  } mreq_t;

  mreq_t mq[$];
  id_t   exp_q[$];
  word_t model_pc;
  int    cyc, mem_lat, acc_cnt, total, bad, n;

  function automatic word_t mem_word(input word_t a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1357};
  endfunction

  function automatic id_t ent(input word_t pc);
    return '{pc: pc, ir: mem_word(pc)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: present any due memory response, then at mid-cycle record requests,
  // sink pops and branches into the memory queue and the scoreboard.
  task automatic cycle();
    if (areset || mq.size() == 0 || mq[0].due > cyc) begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
    end else begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
    #2;
    if (areset) begin
      mq.delete();
      exp_q.delete();
      model_pc = RST_PC;
    end else begin
      if (bus.sink_tvalid && bus.sink_tready && !branch) begin
        chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) chk("sb_sink", bus.sink_tdata, exp_q.pop_front());
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        mq.push_back('{due: cyc + mem_lat, addr: bus.imem_req_addr});
        acc_cnt++;
      end
      if (branch) begin
        chk("req_in_branch", 64'(bus.imem_req_valid), 64'd0);
        exp_q.delete();
        model_pc = target & ~32'h3;
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", 64'(bus.imem_req_addr), 64'(model_pc));
        exp_q.push_back(ent(model_pc));
        model_pc = model_pc + 32'd4;
      end
    end
    @(negedge aclk);
    cyc++;
  endtask

  task automatic wait_valid(input int limit);
    for (int i = 0; i < limit && !bus.sink_tvalid; i++) cycle();
  endtask

  task automatic do_reset(input int lat);
    mem_lat             = lat;
    branch              = 1'b0;
    target              = '0;
    bus.sink_tready     = 1'b1;
    bus.imem_req_ready  = 1'b1;
    areset              = 1'b1;
    #1;
    chk("rst_tvalid", 64'(bus.sink_tvalid), 64'd0);
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_addr", 64'(bus.imem_req_addr), 64'(RST_PC));
    cycle();
    cycle();
    areset = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; acc_cnt = 0; mem_lat = 1; model_pc = RST_PC;
    areset = 1'b1; branch = 1'b0; target = '0;
    bus.sink_tready = 1'b1; bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    @(negedge aclk);

    // sequential stream at full rate
    do_reset(1);
    cycle();
    cycle();
    for (int i = 0; i < 4; i++) begin
      chk("seq_tvalid", 64'(bus.sink_tvalid), 64'd1);
      chk("seq_tdata", bus.sink_tdata, ent(word_t'(i * 4)));
      cycle();
    end

    // decode stall at pc 8
    do_reset(1);
    repeat (4) cycle();
    chk("stall_head", bus.sink_tdata, ent(32'h8));
    bus.sink_tready = 1'b0;
    repeat (5) begin
      cycle();
      chk("stall_tvalid", 64'(bus.sink_tvalid), 64'd1);
      chk("stall_hold", bus.sink_tdata, ent(32'h8));
    end
    chk("stall_req_valid", 64'(bus.imem_req_valid), 64'd0);
    bus.sink_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("release_tvalid", 64'(bus.sink_tvalid), 64'd1);
      chk("release_tdata", bus.sink_tdata, ent(word_t'(8 + i * 4)));
      cycle();
    end

    // slow memory, branch with two requests outstanding
    do_reset(3);
    cycle();
    cycle();
    chk("slow_req_valid", 64'(bus.imem_req_valid), 64'd0);
    branch = 1'b1; target = 32'h100;
    cycle();
    branch = 1'b0;
    wait_valid(20);
    chk("br_tvalid", 64'(bus.sink_tvalid), 64'd1);
    chk("br_first", bus.sink_tdata, ent(32'h100));

    // back-to-back branches, last one wins
    do_reset(3);
    cycle();
    cycle();
    branch = 1'b1; target = 32'h100;
    cycle();
    target = 32'h300;
    cycle();
    branch = 1'b0;
    wait_valid(20);
    chk("b2b_tvalid", 64'(bus.sink_tvalid), 64'd1);
    chk("b2b_first", bus.sink_tdata, ent(32'h300));

    // unaligned target during a full-rate stream
    do_reset(1);
    repeat (4) cycle();
    branch = 1'b1; target = 32'h203;
    cycle();
    branch = 1'b0;
    chk("align_addr", 64'(bus.imem_req_addr), 64'h200);
    wait_valid(10);
    chk("align_first", bus.sink_tdata, ent(32'h200));
    cycle();

    // PC wrap at the top of the address space
    branch = 1'b1; target = 32'hFFFF_FFFC;
    cycle();
    branch = 1'b0;
    chk("wrap_first_addr", 64'(bus.imem_req_addr), 64'hFFFF_FFFC);
    n = acc_cnt;
    for (int i = 0; i < 10 && acc_cnt == n; i++) cycle();
    chk("wrap_next_addr", 64'(bus.imem_req_addr), 64'h0);
    wait_valid(10);
    chk("wrap_sink0", bus.sink_tdata, ent(32'hFFFF_FFFC));
    cycle();
    wait_valid(10);
    chk("wrap_sink1", bus.sink_tdata, ent(32'h0));

    // reset mid-stream with the queue full
    bus.sink_tready = 1'b0;
    repeat (6) cycle();
    chk("full_tvalid", 64'(bus.sink_tvalid), 64'd1);
    chk("full_req_valid", 64'(bus.imem_req_valid), 64'd0);
    do_reset(1);
    #1;
    chk("restart_req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("restart_addr", 64'(bus.imem_req_addr), 64'(RST_PC));
    cycle();
    cycle();
    chk("restart_sink", bus.sink_tdata, ent(RST_PC));

    // random ready/tready/branch traffic, scoreboard-checked
    do_reset(2);
    repeat (300) begin
      bus.imem_req_ready = ($urandom_range(0, 3) != 0);
      bus.sink_tready    = ($urandom_range(0, 3) != 0);
      branch             = ($urandom_range(0, 19) == 0);
      target             = $urandom;
      cycle();
    end
    branch             = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.sink_tready    = 1'b1;
    repeat (12) cycle();
    chk("drain_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("drain_tvalid", 64'(bus.sink_tvalid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
